// File: rtl/pen_pkg.sv
// Shared types for the pen-plotter coordinate path: point record, FSM states
// and the reserved terminator coordinate.
package pen_pkg;

  localparam int COORD_W    = 9;
  localparam int COORD_TERM = 511;

  typedef struct packed {
    logic               down;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_pt_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    FETCH,
    SEND,
    FINISH
  } state_t;

endpackage

// File: rtl/coord_feeder_if.sv
// Host/motor-side bundle for coord_feeder: host writes and session control in,
// held coordinate, strobe and status out.
interface coord_feeder_if #(
  parameter int DEPTH = 64
);
  import pen_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               i_start;
  logic               i_wr_en;
  logic [COORD_W-1:0] i_wr_x;
  logic [COORD_W-1:0] i_wr_y;
  logic               i_wr_down;
  logic               i_end;
  logic               i_request;
  logic [COORD_W-1:0] o_coord_x;
  logic [COORD_W-1:0] o_coord_y;
  logic               o_down;
  logic               o_done;
  logic               o_busy;
  logic [CNT_W-1:0]   o_count;
  logic               o_overflow;

  modport master (
    output i_start, i_wr_en, i_wr_x, i_wr_y, i_wr_down, i_end, i_request,
    input  o_coord_x, o_coord_y, o_down, o_done, o_busy, o_count, o_overflow
  );

  modport slave (
    input  i_start, i_wr_en, i_wr_x, i_wr_y, i_wr_down, i_end, i_request,
    output o_coord_x, o_coord_y, o_down, o_done, o_busy, o_count, o_overflow
  );

endinterface

// File: rtl/coord_fifo.sv
// Single-clock point FIFO with registered read data; a write while full is
// accepted only when a pop happens in the same cycle.
module coord_fifo
  import pen_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  coord_pt_t              i_wr_data,
  input  logic                   i_rd,
  output coord_pt_t              o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  coord_pt_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              rd_ok;
  logic              wr_ok;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign rd_ok   = i_rd && !o_empty;
  assign wr_ok   = i_wr && (!o_full || rd_ok);

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + AW'(1);
        o_rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clock) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/coord_feeder.sv
// Buffers host path points and hands them one per request to the motor
// controller, closing a session with a TERM/TERM point. Option: COORD_FEEDER_DEDUP_EN.
module coord_feeder
  import pen_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int TERM  = COORD_TERM
) (
  input logic           i_clock,
  input logic           i_rst,
  coord_feeder_if.slave bus
);

  localparam logic [COORD_W-1:0] TERM_V = TERM[COORD_W-1:0];

  state_t    state;
  state_t    state_next;
  logic      pending;
  logic      end_flag;
  logic      pop;
  logic      req_eff;
  logic      is_term;
  logic      is_dup;
  logic      wr_req;
  logic      wr_accept;
  logic      fifo_full;
  logic      fifo_empty;
  coord_pt_t wr_pt;
  coord_pt_t rd_pt;

  assign wr_pt     = '{down: bus.i_wr_down, x: bus.i_wr_x, y: bus.i_wr_y};
  assign is_term   = (bus.i_wr_x == TERM_V) && (bus.i_wr_y == TERM_V);
  assign wr_req    = bus.i_wr_en && !is_term && !is_dup;
  assign wr_accept = wr_req && (!fifo_full || pop);
  assign req_eff   = pending || bus.i_request;

`ifdef COORD_FEEDER_DEDUP_EN
  coord_pt_t last_pt;
  logic      last_vld;

  assign is_dup = last_vld && (last_pt == wr_pt);

  // Remembers the last enqueued point so an immediate repeat is swallowed.
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      last_pt  <= '0;
      last_vld <= 1'b0;
    end else if (wr_accept) begin
      last_pt  <= wr_pt;
      last_vld <= 1'b1;
    end else if (state == FINISH) begin
      last_vld <= 1'b0;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  coord_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_rst     (i_rst),
    .i_wr      (wr_req),
    .i_wr_data (wr_pt),
    .i_rd      (pop),
    .o_rd_data (rd_pt),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (bus.o_count)
  );

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // A live request is served in the same cycle so data strobes two cycles later.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:     if (bus.i_start) state_next = WAIT_REQ;
      WAIT_REQ: begin
        if (req_eff) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = FETCH;
          end else if (end_flag) begin
            state_next = FINISH;
          end
        end
      end
      FETCH:    state_next = SEND;
      SEND:     state_next = WAIT_REQ;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      pending        <= 1'b0;
      end_flag       <= 1'b0;
      bus.o_overflow <= 1'b0;
    end else begin
      pending <= (state == WAIT_REQ) && req_eff && fifo_empty && !end_flag;
      if (bus.i_end)           end_flag <= 1'b1;
      else if (state == FINISH) end_flag <= 1'b0;
      if (wr_req && fifo_full && !pop) bus.o_overflow <= 1'b1;
    end
  end

  // The TERM point is loaded on entry to FINISH so it is valid with the strobe.
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      bus.o_coord_x <= '0;
      bus.o_coord_y <= '0;
      bus.o_down    <= 1'b0;
    end else if (state == FETCH) begin
      bus.o_coord_x <= rd_pt.x;
      bus.o_coord_y <= rd_pt.y;
      bus.o_down    <= rd_pt.down;
    end else if (state == WAIT_REQ && state_next == FINISH) begin
      bus.o_coord_x <= TERM_V;
      bus.o_coord_y <= TERM_V;
      bus.o_down    <= 1'b0;
    end
  end

  assign bus.o_done = (state == SEND) || (state == FINISH);
  assign bus.o_busy = (state != IDLE);

endmodule

// File: tb/tb_coord_feeder.sv
// Directed self-checking bench for coord_feeder; expected values are worked out
// by hand from the point sequences written.
module tb_coord_feeder;
  import pen_pkg::*;

  localparam int DEPTH = 64;

  logic i_clock;
  logic i_rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   done_count = 0;
  int   mark;

  coord_feeder_if #(.DEPTH(DEPTH)) bus ();

  coord_feeder #(
    .DEPTH (DEPTH),
    .TERM  (COORD_TERM)
  ) dut (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) if (bus.o_done) done_count++;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int pt(input logic d, input int x, input int y);
    return int'({d, x[8:0], y[8:0]});
  endfunction

  function automatic int outPt();
    return int'({bus.o_down, bus.o_coord_x, bus.o_coord_y});
  endfunction

  task automatic tick();
    @(negedge i_clock);
  endtask

  task automatic applyStimulus(input logic s, input logic w, input int x, input int y,
                               input logic d, input logic e, input logic r);
    bus.i_start   = s;
    bus.i_wr_en   = w;
    bus.i_wr_x    = x[8:0];
    bus.i_wr_y    = y[8:0];
    bus.i_wr_down = d;
    bus.i_end     = e;
    bus.i_request = r;
    tick();
    bus.i_start   = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_end     = 1'b0;
    bus.i_request = 1'b0;
  endtask

  task automatic writePoint(input int x, input int y, input logic d);
    applyStimulus(1'b0, 1'b1, x, y, d, 1'b0, 1'b0);
  endtask

  task automatic requestPulse();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) checkOutput({tag, " timeout"}, 0, 1);
  endtask

  task automatic resetDut();
    bus.i_start = 1'b0; bus.i_wr_en = 1'b0; bus.i_end = 1'b0; bus.i_request = 1'b0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_start = 1'b0; bus.i_wr_en = 1'b0; bus.i_wr_x = '0; bus.i_wr_y = '0;
    bus.i_wr_down = 1'b0; bus.i_end = 1'b0; bus.i_request = 1'b0;
    tick();
    tick();
    checkOutput("reset busy", int'(bus.o_busy), 0);
    checkOutput("reset count", int'(bus.o_count), 0);
    checkOutput("reset overflow", int'(bus.o_overflow), 0);
    checkOutput("reset done", int'(bus.o_done), 0);
    checkOutput("reset coord", outPt(), 0);
    i_rst = 1'b0;
    tick();

    // Basic point with two-cycle latency
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("start busy", int'(bus.o_busy), 1);
    writePoint(10, 20, 1'b1);
    checkOutput("count after write", int'(bus.o_count), 1);
    requestPulse();
    checkOutput("done n+1", int'(bus.o_done), 0);
    tick();
    checkOutput("done n+2", int'(bus.o_done), 1);
    checkOutput("point 10/20/1", outPt(), pt(1'b1, 10, 20));
    tick();
    checkOutput("done one cycle", int'(bus.o_done), 0);
    checkOutput("coord hold", outPt(), pt(1'b1, 10, 20));

    // Stall on empty FIFO until data arrives
    mark = done_count;
    requestPulse();
    repeat (8) tick();
    checkOutput("stall no done", done_count - mark, 0);
    writePoint(5, 5, 1'b0);
    waitDone("stall", 10);
    checkOutput("stall point", outPt(), pt(1'b0, 5, 5));
    repeat (4) tick();
    checkOutput("stall single done", done_count - mark, 1);

    // Three points, end marker, terminator
    writePoint(1, 2, 1'b1);
    writePoint(3, 4, 1'b0);
    writePoint(5, 6, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    requestPulse(); waitDone("seq p1", 10);
    checkOutput("seq p1", outPt(), pt(1'b1, 1, 2)); tick();
    requestPulse(); waitDone("seq p2", 10);
    checkOutput("seq p2", outPt(), pt(1'b0, 3, 4)); tick();
    requestPulse(); waitDone("seq p3", 10);
    checkOutput("seq p3", outPt(), pt(1'b1, 5, 6)); tick();
    requestPulse(); waitDone("seq term", 10);
    checkOutput("seq term", outPt(), pt(1'b0, 511, 511));
    tick();
    checkOutput("seq idle busy", int'(bus.o_busy), 0);
    checkOutput("seq idle done", int'(bus.o_done), 0);

    // Reserved terminator writes are dropped without overflow
    resetDut();
    writePoint(511, 511, 1'b1);
    checkOutput("term drop count", int'(bus.o_count), 0);
    checkOutput("term drop ovf", int'(bus.o_overflow), 0);
    writePoint(511, 5, 1'b0);
    checkOutput("half term kept", int'(bus.o_count), 1);

    // Overfill then drain in order
    resetDut();
    for (int i = 0; i < DEPTH + 2; i++) writePoint(i, i + 100, i[0]);
    checkOutput("full count", int'(bus.o_count), DEPTH);
    checkOutput("full overflow", int'(bus.o_overflow), 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      requestPulse();
      waitDone($sformatf("drain %0d", i), 10);
      checkOutput($sformatf("drain %0d", i), outPt(), pt(i[0], i, i + 100));
      tick();
    end
    checkOutput("drained count", int'(bus.o_count), 0);

    // Simultaneous write and pop keeps the count
    writePoint(30, 31, 1'b1);
    applyStimulus(1'b0, 1'b1, 40, 41, 1'b0, 1'b0, 1'b1);
    checkOutput("wr+pop count", int'(bus.o_count), 1);
    tick();
    checkOutput("wr+pop p1", outPt(), pt(1'b1, 30, 31));
    tick();
    requestPulse(); waitDone("wr+pop p2", 10);
    checkOutput("wr+pop p2", outPt(), pt(1'b0, 40, 41));

    // Duplicate suppression
    resetDut();
    writePoint(7, 7, 1'b1);
    writePoint(7, 7, 1'b1);
    writePoint(8, 7, 1'b1);
`ifdef COORD_FEEDER_DEDUP_EN
    checkOutput("dedup count", int'(bus.o_count), 2);
`else
    checkOutput("dedup count", int'(bus.o_count), 3);
`endif

    // Reset between request and strobe
    resetDut();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    writePoint(9, 9, 1'b1);
    mark = done_count;
    requestPulse();
    i_rst = 1'b1;
    #1;
    checkOutput("midreset done", int'(bus.o_done), 0);
    checkOutput("midreset coord", outPt(), 0);
    checkOutput("midreset count", int'(bus.o_count), 0);
    checkOutput("midreset busy", int'(bus.o_busy), 0);
    tick();
    i_rst = 1'b0;
    repeat (6) tick();
    checkOutput("midreset no done", done_count - mark, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coord_feeder.md
COORD_FEEDER -- requirements
Module: coord_feeder

Interface
REQ-001 SHALL have parameters: DEPTH, default 64, FIFO entries (power of 2); TERM, default 511, reserved terminator coordinate value.
REQ-002 SHALL have ports: i_clock  in  1  system clock, 40 MHz.
REQ-003 SHALL have ports: i_rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have ports: i_start  in  1  start a path session, pulse.
REQ-005 SHALL have ports: i_wr_en  in  1, i_wr_x  in  9, i_wr_y  in  9, i_wr_down  in  1: host point write.
REQ-006 SHALL have ports: i_end  in  1  pulse, host marks path complete.
REQ-007 SHALL have ports: i_request  in  1  next-coordinate request from motor controller, pulse.
REQ-008 SHALL have ports: o_coord_x  out  9, o_coord_y  out  9, o_down  out  1: held coordinate and pen state.
REQ-009 SHALL have ports: o_done  out  1  one-cycle coordinate-valid strobe; o_busy  out  1  state != IDLE; o_count  out  log2(DEPTH)+1  FIFO fill; o_overflow  out  1  sticky.

Function
REQ-010 SHALL implement states IDLE, WAIT_REQ, FETCH, SEND, FINISH.
REQ-011 SHALL move IDLE->WAIT_REQ on i_start; i_start in any other state is ignored.
REQ-012 SHALL latch i_request into a pending flag in WAIT_REQ; requests in IDLE/FETCH/SEND/FINISH are ignored.
REQ-013 WAIT_REQ with pending and FIFO non-empty SHALL pop one entry and go to FETCH; pending clears.
REQ-014 WAIT_REQ with pending, FIFO empty and end flag set SHALL go to FINISH; FIFO empty without end flag SHALL stall, pending held.
REQ-015 FETCH SHALL register popped entry onto o_coord_x/y/o_down, then SEND asserts o_done one cycle, then WAIT_REQ; request in cycle N yields o_done in cycle N+2 when data present.
REQ-016 FINISH SHALL drive o_coord_x=o_coord_y=TERM, o_down=0, o_done=1 for one cycle, clear end flag, return to IDLE.
REQ-017 Outputs o_coord_x/y/o_down SHALL hold between strobes.
REQ-018 Writes SHALL be accepted in every state; write when full SHALL be dropped and set o_overflow.
REQ-019 Writes with i_wr_x==TERM and i_wr_y==TERM SHALL be dropped (reserved), o_overflow unaffected.
REQ-020 Simultaneous write and pop SHALL both occur, o_count unchanged; write-to-full with simultaneous pop SHALL be accepted.
REQ-021 i_end SHALL set the end flag in any state; i_end and a write in the same cycle: write counts as before the end.
REQ-022 Pointers SHALL wrap modulo DEPTH; o_count range 0..DEPTH.

Reset
REQ-023 i_rst high SHALL immediately force IDLE, FIFO empty, o_count=0, pending=0, end flag=0, o_overflow=0, o_done=0, o_coord_x=o_coord_y=0, o_down=0, o_busy=0.
REQ-024 Reset mid-session SHALL discard all buffered points; no o_done after release until a new request.

Configuration
REQ-025 With COORD_FEEDER_DEDUP_EN defined, a write equal in {down,x,y} to the last accepted write SHALL be dropped silently; last-write register cleared by reset and FINISH.
REQ-026 Without COORD_FEEDER_DEDUP_EN, every valid write SHALL be enqueued; no last-write register.

Structure
REQ-027 Shared package pen_pkg SHALL hold coord_pt_t struct {down,x[8:0],y[8:0]}, state enum, COORD_TERM=511, COORD_W=9.
REQ-028 FIFO SHALL be sub-module coord_fifo (single clock, registered read, full/empty/count).

Verification
REQ-029 Reset, start, write (10,20,down=1), request -> o_done two cycles later with 10/20/1.
REQ-030 Request with empty FIFO, no end; write (5,5,0) 8 cycles later -> single o_done with 5/5/0, none before.
REQ-031 Write 3 points, i_end, 4 requests -> 3 points in order then 511/511 down=0, state IDLE, o_busy=0.
REQ-032 DEPTH+2 writes without pop -> o_count=DEPTH, o_overflow=1; reads return first DEPTH points.
REQ-033 With COORD_FEEDER_DEDUP_EN: writes (7,7,1),(7,7,1),(8,7,1) -> o_count=2; without: o_count=3.
REQ-034 Assert i_rst between request and o_done -> no o_done, all outputs zero, o_count=0.
